// File: rtl/life_rle_loader.sv
// rtl/life_rle_loader.sv - RLE Life pattern decoder issuing packed byte writes to the frame SRAM
//
// Decodes an RLE pattern, one ASCII character per accepted byte, into packed
// 8-cell bytes. Bit 7 of each byte is the leftmost cell. Each byte is written
// through a single-outstanding request/acknowledge handshake.
//
// Ports:
//   clk_pixel, rst          pixel clock; asynchronous active-high reset
//   start, origin_addr      one-cycle load request and the pattern's top-left byte address
//   in_data/in_valid/in_ready  RLE character stream (accepted when valid and ready)
//   wr_addr/wr_data/wr_req/wr_ack  registered SRAM write request, held until acknowledged
//   busy, done, error       load in progress, end-of-pattern pulse, sticky parse error
//
// Build option: define LIFE_RLE_CLIP_EN to drop writes that fall past the
// right edge of the display row.
`timescale 1ns/1ps
module life_rle_loader #(
   parameter int ROW_BYTES = 200,
   parameter int RUN_W     = 12
) (
   input  logic        clk_pixel,
   input  logic        rst,
   input  logic        start,
   input  logic [18:0] origin_addr,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [18:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        wr_req,
   input  logic        wr_ack,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam logic [7:0] CH_B   = 8'h62;  // 'b' dead cell
   localparam logic [7:0] CH_O   = 8'h6F;  // 'o' live cell
   localparam logic [7:0] CH_EOL = 8'h24;  // '$' end of row
   localparam logic [7:0] CH_END = 8'h21;  // '!' end of pattern
   localparam logic [7:0] CH_SP  = 8'h20;
   localparam logic [7:0] CH_LF  = 8'h0A;
   localparam logic [7:0] CH_CR  = 8'h0D;
   localparam logic [7:0] CH_0   = 8'h30;
   localparam logic [7:0] CH_9   = 8'h39;

   localparam logic [18:0]      ROW_INC = 19'(ROW_BYTES);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
   localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_PARSE,
      S_EMIT,
      S_FLUSH,
      S_ROWADV,
      S_FIN,
      S_WAIT_ACK
   } state_t;

   state_t           state;
   state_t           ret_state;   // where WAIT_ACK resumes once the write is acknowledged
   logic [18:0]      cur_addr;    // byte currently being filled
   logic [18:0]      line_addr;   // first byte of the current pattern row
   logic [2:0]       bit_pos;     // cells already shifted into the current byte
   logic [7:0]       shift;
   logic [RUN_W-1:0] count;       // decimal run prefix being accumulated
   logic [RUN_W-1:0] run;         // cells or rows still to process for the current token
   logic             cell_val;
   logic             is_bang;     // the pending flush was triggered by '!'

   logic             is_digit;
   logic             is_ws;
   logic [RUN_W+3:0] count_x10;
   logic [RUN_W-1:0] count_sat;
   logic [RUN_W-1:0] eff_run;
   logic [7:0]       shift_next;
   logic [7:0]       flush_data;
   logic [18:0]      line_next;
   logic             clip;
   state_t           emit_next;
   state_t           flush_next;

   assign is_digit = (in_data >= CH_0) && (in_data <= CH_9);
   assign is_ws    = (in_data == CH_SP) || (in_data == CH_LF) || (in_data == CH_CR);

   // count*10 + digit in a widened accumulator, then clamp to the run width.
   assign count_x10 = ({4'b0000, count} << 3) + ({4'b0000, count} << 1)
                    + {{RUN_W{1'b0}}, in_data[3:0]};
   assign count_sat = (count_x10 > {4'b0000, RUN_MAX}) ? RUN_MAX : count_x10[RUN_W-1:0];
   assign eff_run   = (count == '0) ? RUN_ONE : count;

   assign shift_next = {shift[6:0], cell_val};
   // Older cells above bit_pos fall off the top, leaving the partial byte
   // left-aligned with zero padding for the dead cells.
   assign flush_data = shift << (4'd8 - {1'b0, bit_pos});
   assign line_next  = line_addr + ROW_INC;

   assign emit_next  = (run == RUN_ONE) ? S_PARSE : S_EMIT;
   assign flush_next = is_bang ? S_FIN : S_ROWADV;

`ifdef LIFE_RLE_CLIP_EN
   // The column is measured from the left edge of the display row, so a
   // pattern placed near the right edge is cut at the screen boundary rather
   // than wrapping onto the next scanline.
   logic [18:0] col_base;
   logic [18:0] col;

   assign col  = col_base + (cur_addr - line_addr);
   assign clip = (col >= ROW_INC);

   always_ff @(posedge clk_pixel or posedge rst) begin
      if (rst) begin
         col_base <= '0;
      end else if (state == S_IDLE && start) begin
         col_base <= 19'(origin_addr % ROW_BYTES);
      end
   end
`else
   assign clip = 1'b0;
`endif

   assign in_ready = (state == S_PARSE);
   assign busy     = (state != S_IDLE);

   always_ff @(posedge clk_pixel or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         ret_state <= S_PARSE;
         cur_addr  <= '0;
         line_addr <= '0;
         bit_pos   <= '0;
         shift     <= '0;
         count     <= '0;
         run       <= '0;
         cell_val  <= 1'b0;
         is_bang   <= 1'b0;
         wr_req    <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  cur_addr  <= origin_addr;
                  line_addr <= origin_addr;
                  bit_pos   <= '0;
                  shift     <= '0;
                  count     <= '0;
                  error     <= 1'b0;
                  state     <= S_PARSE;
               end
            end

            S_PARSE: begin
               if (in_valid) begin
                  if (is_digit) begin
                     count <= count_sat;
                  end else if (is_ws) begin
                     count <= count;
                  end else if (in_data == CH_B || in_data == CH_O) begin
                     run      <= eff_run;
                     count    <= '0;
                     cell_val <= (in_data == CH_O);
                     state    <= S_EMIT;
                  end else if (in_data == CH_EOL) begin
                     run     <= eff_run;
                     count   <= '0;
                     is_bang <= 1'b0;
                     state   <= S_FLUSH;
                  end else if (in_data == CH_END) begin
                     count   <= '0;
                     is_bang <= 1'b1;
                     state   <= S_FLUSH;
                  end else begin
                     // Unknown character: abandon the load, partial byte is dropped.
                     error <= 1'b1;
                     state <= S_IDLE;
                  end
               end
            end

            S_EMIT: begin
               shift   <= shift_next;
               bit_pos <= bit_pos + 3'd1;
               run     <= run - RUN_ONE;
               if (bit_pos == 3'd7) begin
                  cur_addr <= cur_addr + 19'd1;
                  if (!clip) begin
                     wr_req    <= 1'b1;
                     wr_addr   <= cur_addr;
                     wr_data   <= shift_next;
                     ret_state <= emit_next;
                     state     <= S_WAIT_ACK;
                  end else begin
                     state <= emit_next;
                  end
               end else begin
                  state <= emit_next;
               end
            end

            S_FLUSH: begin
               bit_pos <= '0;
               shift   <= '0;
               if (bit_pos != 3'd0 && !clip) begin
                  wr_req    <= 1'b1;
                  wr_addr   <= cur_addr;
                  wr_data   <= flush_data;
                  ret_state <= flush_next;
                  state     <= S_WAIT_ACK;
               end else begin
                  done  <= is_bang;
                  state <= flush_next;
               end
            end

            S_ROWADV: begin
               line_addr <= line_next;
               run       <= run - RUN_ONE;
               if (run == RUN_ONE) begin
                  cur_addr <= line_next;
                  state    <= S_PARSE;
               end
            end

            S_FIN: begin
               state <= S_IDLE;
            end

            S_WAIT_ACK: begin
               if (wr_ack) begin
                  wr_req <= 1'b0;
                  done   <= (ret_state == S_FIN);
                  state  <= ret_state;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
